// File: rtl/rhd_spi_frame_engine.sv
// SPI frame engine for one RHD2000 headstage port: steps channels, shifts MOSI, captures MISO.
// Optional build macro RHD_MISO_DELAY_EN adds a cable-delay line on the MISO sample strobe.
module rhd_spi_frame_engine #(
    parameter int CLK_DIV        = 2,
    parameter int CS_HIGH_CYCLES = 4,
    parameter int NUM_CHANNELS   = 35
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] mosi_cmd,
    input  logic        miso,
    input  logic [3:0]  miso_delay,
    output logic [5:0]  channel,
    output logic        cs_b,
    output logic        sclk,
    output logic        mosi,
    output logic [15:0] miso_word,
    output logic [5:0]  miso_channel,
    output logic        miso_valid,
    output logic        sample_done,
    output logic        busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CS_SETUP = 3'd1;
    localparam logic [2:0] SHIFT    = 3'd2;
    localparam logic [2:0] CS_HOLD  = 3'd3;
    localparam logic [2:0] CS_HIGH  = 3'd4;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HIGH_LAST = 16'(CS_HIGH_CYCLES - 1);
    localparam logic [5:0]  LAST_CH   = 6'(NUM_CHANNELS - 1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic        hi;
    logic [3:0]  bit_cnt;
    logic [15:0] tx;
    logic [15:0] rx;
    logic [15:0] tx_load;
    logic        load;
    logic        strobe;
    logic        capture;
    logic [15:0] hold_last;

    always_comb begin
        load    = (state == CS_SETUP) && (cnt == DIV_LAST);
        tx_load = load ? mosi_cmd : tx;
        strobe  = (state == SHIFT) && hi && (cnt == 16'd0);
    end

`ifdef RHD_MISO_DELAY_EN
    logic [3:0]  dly_q;
    logic [14:0] dline;

    // Delay latched once per frame so a mid-frame change cannot split the strobes.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            dly_q <= 4'd0;
            dline <= 15'd0;
        end else begin
            dline <= {dline[13:0], strobe};
            if (load) dly_q <= miso_delay;
        end
    end

    always_comb begin
        capture   = (dly_q == 4'd0) ? strobe : dline[dly_q - 4'd1];
        hold_last = DIV_LAST + {12'd0, dly_q};
    end
`else
    logic unused_delay;

    assign unused_delay = ^miso_delay;

    always_comb begin
        capture   = strobe;
        hold_last = DIV_LAST;
    end
`endif

    // Shift registers carry data only; they are fully rewritten every frame.
    always_ff @(posedge dataclk) begin
        if (load) tx <= mosi_cmd;
        else if (strobe) tx <= {tx[14:0], 1'b0};
        if (capture) rx <= {rx[14:0], miso};
    end

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            hi           <= 1'b0;
            bit_cnt      <= 4'd0;
            channel      <= 6'd0;
            cs_b         <= 1'b1;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            miso_word    <= 16'd0;
            miso_channel <= 6'd0;
            miso_valid   <= 1'b0;
            sample_done  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            miso_valid  <= 1'b0;
            sample_done <= 1'b0;
            case (state)
                IDLE: begin
                    channel <= 6'd0;
                    if (run) begin
                        state <= CS_SETUP;
                        cnt   <= DIV_LAST;
                        cs_b  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                CS_SETUP: begin
                    if (cnt == 16'd0) begin
                        state   <= SHIFT;
                        cnt     <= DIV_LAST;
                        hi      <= 1'b0;
                        bit_cnt <= 4'd0;
                        mosi    <= tx_load[15];
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (!hi) begin
                        hi   <= 1'b1;
                        sclk <= 1'b1;
                        cnt  <= DIV_LAST;
                    end else begin
                        hi   <= 1'b0;
                        sclk <= 1'b0;
                        if (bit_cnt == 4'd15) begin
                            state <= CS_HOLD;
                            mosi  <= 1'b0;
                            cnt   <= hold_last;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            mosi    <= tx[14];
                            cnt     <= DIV_LAST;
                        end
                    end
                end
                CS_HOLD: begin
                    if (cnt == 16'd0) begin
                        state        <= CS_HIGH;
                        cnt          <= HIGH_LAST;
                        cs_b         <= 1'b1;
                        miso_valid   <= 1'b1;
                        miso_word    <= rx;
                        miso_channel <= channel;
                        if (HIGH_LAST == 16'd0 && channel == LAST_CH) sample_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                CS_HIGH: begin
                    // sample_done is raised so that it is visible during the final CS_HIGH cycle.
                    if (cnt == 16'd1 && channel == LAST_CH) sample_done <= 1'b1;
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (channel == LAST_CH) begin
                        channel <= 6'd0;
                        if (run) begin
                            state <= CS_SETUP;
                            cnt   <= DIV_LAST;
                            cs_b  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        channel <= channel + 6'd1;
                        state   <= CS_SETUP;
                        cnt     <= DIV_LAST;
                        cs_b    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cs_b  <= 1'b1;
                    sclk  <= 1'b0;
                    mosi  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rhd_spi_frame_engine.sv
// Directed bench for rhd_spi_frame_engine with a command selector and headstage MISO model.
// Define RHD_MISO_DELAY_EN to add the cable-delay scenario.
module tb_rhd_spi_frame_engine;

    logic        dataclk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] mosi_cmd;
    logic        miso = 1'b0;
    logic [3:0]  miso_delay;
    logic [5:0]  channel;
    logic        cs_b;
    logic        sclk;
    logic        mosi;
    logic [15:0] miso_word;
    logic [5:0]  miso_channel;
    logic        miso_valid;
    logic        sample_done;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;
    int cycle_no   = 0;
    int exp_d      = 0;
    int tb_dly     = 0;
    bit fixed_reply = 1'b0;

    logic [15:0] cur_reply = 16'd0;
    int          bitk = 16;
    logic        sp = 1'b0;
    logic        csp = 1'b1;
    logic        ideal = 1'b0;
    logic [15:0] hist = 16'd0;

    rhd_spi_frame_engine dut (
        .dataclk(dataclk), .reset(reset), .run(run), .mosi_cmd(mosi_cmd),
        .miso(miso), .miso_delay(miso_delay), .channel(channel), .cs_b(cs_b),
        .sclk(sclk), .mosi(mosi), .miso_word(miso_word), .miso_channel(miso_channel),
        .miso_valid(miso_valid), .sample_done(sample_done), .busy(busy)
    );

    always #5 dataclk = ~dataclk;
    always @(posedge dataclk) cycle_no++;

    // Selector: CONVERT(channel) command.
    assign mosi_cmd = {2'b00, channel, 8'h00};

    function automatic logic [15:0] reply_of(input logic [5:0] c);
        if (fixed_reply) return 16'h1234;
        if (c == 6'd5) return 16'hA5C3;
        return {8'h3C, 2'b00, c};
    endfunction

    // Headstage: new bit after each sclk rise, optionally delayed by the cable.
    always @(negedge dataclk) begin
        if (reset) begin
            bitk  = 16;
            ideal = 1'b0;
        end else begin
            if (!cs_b && csp) begin
                cur_reply = reply_of(channel);
                bitk = 0;
            end
            if (sclk && !sp && bitk < 16) begin
                ideal = cur_reply[15 - bitk];
                bitk++;
            end
        end
        sp   = sclk;
        csp  = cs_b;
        hist = {hist[14:0], ideal};
        miso = hist[tb_dly];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs_fall(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge dataclk);
            if (!cs_b) begin
                lat = i;
                break;
            end
        end
    endtask

    // Starts at cycle 1 of a frame; returns at cycle 1 of the next frame or the first idle cycle.
    task automatic run_frame(output logic [15:0] mw, output int rises, output int first_rise,
                             output int cs_low, output int vld_cyc, output logic [15:0] vld_word,
                             output int vld_chan, output int done_cyc, output int len,
                             output bit to_idle);
        logic prev_s;
        logic prev_cs;
        mw = 16'd0; rises = 0; first_rise = -1; cs_low = 0; vld_cyc = -1;
        vld_word = 16'd0; vld_chan = 63; done_cyc = 0; len = -1; to_idle = 1'b0;
        prev_s = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (!cs_b) cs_low++;
            if (sclk && !prev_s) begin
                rises++;
                if (first_rise < 0) first_rise = cyc;
                mw = {mw[14:0], mosi};
            end
            prev_s = sclk;
            if (miso_valid) begin
                vld_cyc  = cyc;
                vld_word = miso_word;
                vld_chan = int'(miso_channel);
            end
            if (sample_done) done_cyc = cyc;
            prev_cs = cs_b;
            @(negedge dataclk);
            if (!cs_b && prev_cs) begin
                len = cyc;
                break;
            end
            if (!busy) begin
                len = cyc;
                to_idle = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input int ch, input bit exp_idle);
        logic [15:0] mw, vw;
        int rises, fr, csl, vc, vch, dc, len;
        bit ti;
        string b;
        b = $sformatf("ch%0d", ch);
        run_frame(mw, rises, fr, csl, vc, vw, vch, dc, len, ti);
        check({b, "_mosi"}, mw, {2'b00, 6'(ch), 8'h00});
        check({b, "_sclk_rises"}, rises, 16);
        check({b, "_first_rise"}, fr, 5);
        check({b, "_cs_low"}, csl, 68 + exp_d);
        check({b, "_valid_cycle"}, vc, 69 + exp_d);
        check({b, "_miso_word"}, vw, reply_of(6'(ch)));
        check({b, "_miso_channel"}, vch, ch);
        check({b, "_done_cycle"}, dc, (ch == 34) ? 72 + exp_d : 0);
        check({b, "_frame_len"}, len, 72 + exp_d);
        check({b, "_to_idle"}, ti, exp_idle);
    endtask

    task automatic check_reset_values(input string b);
        check({b, "_cs_b"}, cs_b, 1);
        check({b, "_sclk"}, sclk, 0);
        check({b, "_mosi"}, mosi, 0);
        check({b, "_channel"}, channel, 0);
        check({b, "_miso_word"}, miso_word, 0);
        check({b, "_miso_channel"}, miso_channel, 0);
        check({b, "_miso_valid"}, miso_valid, 0);
        check({b, "_sample_done"}, sample_done, 0);
        check({b, "_busy"}, busy, 0);
    endtask

    initial begin
        int lat;
        int seq_start;
        int vcnt;
        reset = 1'b1;
        run   = 1'b0;
`ifdef RHD_MISO_DELAY_EN
        miso_delay = 4'd0;
`else
        miso_delay = 4'd7;
`endif
        repeat (3) @(negedge dataclk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge dataclk);
        run = 1'b1;
        wait_cs_fall(lat);
        check("start_latency", lat, 1);

        // Two back-to-back sequences with run held high.
        for (int s = 0; s < 2; s++) begin
            seq_start = cycle_no;
            for (int ch = 0; ch < 35; ch++) check_frame(ch, 1'b0);
            check($sformatf("seq%0d_period", s), cycle_no - seq_start, 2520);
        end

        // Drop run during channel 10; sequence must still complete.
        for (int ch = 0; ch < 10; ch++) check_frame(ch, 1'b0);
        run = 1'b0;
        for (int ch = 10; ch < 34; ch++) check_frame(ch, 1'b0);
        check_frame(34, 1'b1);
        check("stop_busy", busy, 0);
        check("stop_cs_b", cs_b, 1);
        check("stop_channel", channel, 0);
        repeat (5) @(negedge dataclk);
        check("idle_cs_b", cs_b, 1);
        check("idle_busy", busy, 0);

        // Reset in the middle of SHIFT on channel 20.
        run = 1'b1;
        wait_cs_fall(lat);
        check("restart_latency", lat, 1);
        for (int ch = 0; ch < 20; ch++) check_frame(ch, 1'b0);
        check("pre_rst_channel", channel, 20);
        repeat (29) @(negedge dataclk);
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_reset_values("midrst");
        vcnt = 0;
        repeat (3) begin
            @(negedge dataclk);
            if (miso_valid) vcnt++;
        end
        check("midrst_no_valid", vcnt, 0);
        reset = 1'b0;
        wait_cs_fall(lat);
        check("post_rst_latency", lat, 1);
        check_frame(0, 1'b0);
        check_frame(1, 1'b0);

`ifdef RHD_MISO_DELAY_EN
        reset = 1'b1;
        run   = 1'b0;
        miso_delay  = 4'd3;
        tb_dly      = 3;
        exp_d       = 3;
        fixed_reply = 1'b1;
        repeat (2) @(negedge dataclk);
        reset = 1'b0;
        @(negedge dataclk);
        run = 1'b1;
        wait_cs_fall(lat);
        check("dly_latency", lat, 1);
        check_frame(0, 1'b0);
        check_frame(1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rhd_spi_frame_engine.md
Name: rhd_spi_frame_engine

Overview:
- SPI master for one RHD2000 headstage port. Steps the channel index 0..NUM_CHANNELS-1 that drives the MOSI command selector, then serialises the selected 16-bit MOSI command.
- Generates cs_b and sclk, and captures the 16-bit MISO reply for each frame.
- Sits between the sample-rate/run control logic and the per-channel data FIFO.

Parameters:
- CLK_DIV, 2: SCLK half-period in dataclk cycles (>=1).
- CS_HIGH_CYCLES, 4: cs_b high time between frames, in dataclk cycles (>=1).
- NUM_CHANNELS, 35: frames per sample sequence (channels 0..31 CONVERT, 32..34 aux).

Ports:
- dataclk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; enables sample sequences
- mosi_cmd  in  16  command for the current channel (from selector, combinational on channel)
- miso  in  1  serial data from headstage
- miso_delay  in  4  cable-delay compensation in dataclk cycles (used only with the macro)
- channel  out  6  current frame index, to selector
- cs_b  out  1  chip select, active low
- sclk  out  1  serial clock, idle low
- mosi  out  1  serial data out, MSB first
- miso_word  out  16  captured reply
- miso_channel  out  6  channel index of miso_word
- miso_valid  out  1  one-cycle strobe; miso_word/miso_channel valid
- sample_done  out  1  one-cycle strobe at the end of channel NUM_CHANNELS-1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time including mid-frame): state=IDLE, cs_b=1, sclk=0, mosi=0, channel=0, miso_word=0, miso_channel=0, miso_valid=0, sample_done=0, busy=0. No partial frame completes.
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_HIGH.
- IDLE: cs_b=1, sclk=0, channel=0. If run=1, go to CS_SETUP on the next edge.
- CS_SETUP (CLK_DIV cycles): cs_b=0, sclk=0. The 16-bit TX shift register loads mosi_cmd on the edge ending the first CS_SETUP cycle. The channel is already stable at that point.
- SHIFT (16 bits x 2*CLK_DIV cycles):
  - Each bit has a low phase (sclk=0, CLK_DIV cycles) followed by a high phase (sclk=1, CLK_DIV cycles).
  - mosi = TX MSB throughout SHIFT. TX shifts left at the end of each high phase.
  - A sample strobe fires in the last cycle of each high phase. On the strobe, RX = {RX[14:0], miso}.
- CS_HOLD (CLK_DIV cycles): cs_b=0, sclk=0, mosi=0.
- CS_HIGH (CS_HIGH_CYCLES cycles): cs_b=1.
  - First CS_HIGH cycle: miso_valid=1, miso_word=RX, miso_channel=channel.
  - Last CS_HIGH cycle, channel<NUM_CHANNELS-1: channel increments, go to CS_SETUP.
  - Last CS_HIGH cycle, channel=NUM_CHANNELS-1: sample_done=1, channel returns to 0. If run=1, go to CS_SETUP (no idle gap); else go to IDLE.
- run is checked only in IDLE and at sequence end. Dropping run mid-sequence finishes all NUM_CHANNELS frames.
- Frame length = 2*CLK_DIV + 32*CLK_DIV + CS_HIGH_CYCLES. Defaults give 72 cycles; a sequence is 35*72 = 2520 cycles.
- sclk, cs_b and mosi are driven directly from registers (glitch-free).
- miso_word/miso_channel hold their value until the next miso_valid.

Optional Feature:
- Macro: RHD_MISO_DELAY_EN.
- Defined:
  - miso_delay is latched at the start of each frame.
  - The sample strobe passes through a delay line and fires miso_delay dataclk cycles later (0..15).
  - CS_HOLD lengthens to CLK_DIV+miso_delay cycles so all 16 delayed strobes land before CS_HIGH.
  - miso_delay=0 behaves identically to the undefined build.
- Undefined: miso_delay is ignored, there is no delay line, and CS_HOLD=CLK_DIV.

Test Plan:
- Reset, then run=1 with defaults and mosi_cmd driven by the selector model -> cs_b falls 1 cycle after run is seen; 16 sclk pulses of 4-cycle period; mosi shows {2'b00, 6'd0, 8'h00} for channel 0; frames repeat every 72 cycles.
- miso model returns 16'hA5C3 for channel 5 -> miso_valid pulse with miso_word=16'hA5C3, miso_channel=5.
- Hold run=1 across two sequences -> sample_done every 2520 cycles at channel 34; channel 0 frame follows with no IDLE cycle.
- Drop run during channel 10 -> frames continue through channel 34, sample_done=1, then IDLE with busy=0 and cs_b=1.
- Assert reset mid-SHIFT on channel 20 -> all outputs take reset values immediately; no miso_valid; run=1 restarts at channel 0.
- RHD_MISO_DELAY_EN, miso_delay=3, miso model delayed 3 cycles returning 16'h1234 -> miso_word=16'h1234; frame = 75 cycles.
